// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - multi-cycle ALU: one-cycle ops plus shift-add multiply, {Z,C,N,V} flags
`ifndef EXEC_COMMAND_LEN
`define EXEC_COMMAND_LEN 4
`endif
`ifndef EXEC_MOV
`define EXEC_MOV 4'd0
`define EXEC_MVN 4'd1
`define EXEC_AND 4'd2
`define EXEC_TST 4'd3
`define EXEC_ORR 4'd4
`define EXEC_EOR 4'd5
`define EXEC_LDR 4'd6
`define EXEC_STR 4'd7
`define EXEC_ADD 4'd8
`define EXEC_ADC 4'd9
`define EXEC_SUB 4'd10
`define EXEC_SBC 4'd11
`define EXEC_CMP 4'd12
`endif
`ifndef EXEC_MUL
`define EXEC_MUL 4'd13
`endif

module alu_multicycle #(
    parameter int WIDTH  = 32,
    parameter int MUL_EN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             val_1,
    input  logic [WIDTH-1:0]             val_2,
    input  logic [`EXEC_COMMAND_LEN-1:0] exec_cmd,
    input  logic                         s_bit,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             res,
    output logic [3:0]                   status_reg
);
    localparam int CW     = $clog2(WIDTH + 1);
    localparam bit MUL_ON = (MUL_EN != 0);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]             a_q, b_q, acc, mcand, mplier;
    logic [`EXEC_COMMAND_LEN-1:0] cmd_q;
    logic                         s_q, c_q;
    logic [CW-1:0]                cnt;

    logic             xfer_in, is_mul, mul_step, finish;
    logic             sub_op, cin, arith_op, logic_op, commit, ovf;
    logic [WIDTH-1:0] b_eff, result;
    logic [WIDTH:0]   sum;
    logic [3:0]       flags_nxt;

    assign xfer_in  = in_valid & in_ready;
    assign is_mul   = MUL_ON && (cmd_q == `EXEC_MUL);
    assign mul_step = (state == BUSY) && is_mul && (cnt != CW'(WIDTH));
    assign finish   = (state == BUSY) && !mul_step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = BUSY;
            end
            BUSY: if (finish) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready) state_nxt = in_valid ? BUSY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Subtraction is a + ~b + cin, so carry out doubles as "no borrow".
    always_comb begin
        sub_op   = 1'b0;
        cin      = 1'b0;
        arith_op = 1'b0;
        case (cmd_q)
            `EXEC_ADD:            arith_op = 1'b1;
            `EXEC_ADC: begin      arith_op = 1'b1; cin = c_q; end
            `EXEC_SUB, `EXEC_CMP: begin arith_op = 1'b1; sub_op = 1'b1; cin = 1'b1; end
            `EXEC_SBC: begin      arith_op = 1'b1; sub_op = 1'b1; cin = c_q; end
            `EXEC_STR: begin      sub_op = 1'b1; cin = 1'b1; end
            default: ;
        endcase
    end

    assign b_eff = sub_op ? ~b_q : b_q;
    assign sum   = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign ovf   = (a_q[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);

    always_comb begin
        result   = '0;
        logic_op = 1'b0;
        case (cmd_q)
            `EXEC_MOV: begin result = b_q;         logic_op = 1'b1; end
            `EXEC_MVN: begin result = ~b_q;        logic_op = 1'b1; end
            `EXEC_AND, `EXEC_TST: begin result = a_q & b_q; logic_op = 1'b1; end
            `EXEC_ORR: begin result = a_q | b_q;   logic_op = 1'b1; end
            `EXEC_EOR: begin result = a_q ^ b_q;   logic_op = 1'b1; end
            `EXEC_MUL: begin result = is_mul ? acc : '0; logic_op = is_mul; end
            `EXEC_LDR, `EXEC_STR, `EXEC_ADD, `EXEC_ADC,
            `EXEC_SUB, `EXEC_SBC, `EXEC_CMP: result = sum[WIDTH-1:0];
            default: result = '0;
        endcase
        commit = (cmd_q == `EXEC_CMP) || (cmd_q == `EXEC_TST) ||
                 (s_q && (arith_op || logic_op));
        flags_nxt = arith_op
                  ? {result == '0, sum[WIDTH], result[WIDTH-1], ovf}
                  : {result == '0, status_reg[2], result[WIDTH-1], status_reg[0]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            cmd_q      <= '0;
            s_q        <= 1'b0;
            c_q        <= 1'b0;
            acc        <= '0;
            mcand      <= '0;
            mplier     <= '0;
            cnt        <= '0;
            res        <= '0;
            status_reg <= 4'b0000;
        end else if (xfer_in) begin
            a_q    <= val_1;
            b_q    <= val_2;
            cmd_q  <= exec_cmd;
            s_q    <= s_bit;
            c_q    <= status_reg[2];
            acc    <= '0;
            mcand  <= val_1;
            mplier <= val_2;
            cnt    <= '0;
        end else if (mul_step) begin
            // One multiplier bit per cycle; only the low WIDTH product bits are kept.
            acc    <= acc + (mplier[0] ? mcand : '0);
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end else if (finish) begin
            res <= result;
            if (commit) status_reg <= flags_nxt;
        end
    end
endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - scoreboard bench for alu_multicycle with a behavioural reference model
module tb_alu_multicycle;
    localparam int W = 32;
    localparam logic [3:0] OP_MOV = 4'd0,  OP_MVN = 4'd1,  OP_AND = 4'd2,  OP_TST = 4'd3,
                           OP_ORR = 4'd4,  OP_EOR = 4'd5,  OP_LDR = 4'd6,  OP_STR = 4'd7,
                           OP_ADD = 4'd8,  OP_ADC = 4'd9,  OP_SUB = 4'd10, OP_SBC = 4'd11,
                           OP_CMP = 4'd12, OP_MUL = 4'd13;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, s_bit, out_valid, out_ready;
    logic [W-1:0] val_1, val_2, res;
    logic [3:0]   exec_cmd, status_reg;
    logic         forced_ready, rand_ready, rnd_ready;

    logic         in_valid8, in_ready8, s8, out_valid8, out_ready8;
    logic [7:0]   a8, b8, res8;
    logic [3:0]   cmd8, status8;

    always #5 clk = ~clk;
    assign out_ready = rand_ready ? rnd_ready : forced_ready;

    alu_multicycle #(.WIDTH(W), .MUL_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .val_1(val_1), .val_2(val_2), .exec_cmd(exec_cmd), .s_bit(s_bit),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .status_reg(status_reg)
    );

    alu_multicycle #(.WIDTH(8), .MUL_EN(1)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .val_1(a8), .val_2(b8), .exec_cmd(cmd8), .s_bit(s8),
        .out_valid(out_valid8), .out_ready(out_ready8), .res(res8), .status_reg(status8)
    );

    int           n_cmp = 0;
    int           n_fail = 0;
    int           cyc = 0;
    int           last_acc = 0;
    logic [3:0]   m_flags = 4'b0000;
    logic [W+3:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_ready = ($urandom_range(0, 3) != 0);
    end

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Reference: flags from true unsigned/signed arithmetic, applied in issue order.
    function automatic logic [W+3:0] model(input logic [3:0] cmd, input logic [W-1:0] a,
                                           input logic [W-1:0] b, input logic s);
        longint unsigned ua, ub, mask;
        longint          sa, sb, sr, smax, smin;
        logic [W-1:0]    r;
        logic            cn, v, upd;
        int              bor;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        mask = (longint'(1) << W) - 1;
        smax = (longint'(1) << (W - 1)) - 1;
        smin = -smax - 1;
        cn = m_flags[2]; v = m_flags[0]; upd = 1'b1; r = '0; bor = 0;
        case (cmd)
            OP_MOV: r = b;
            OP_MVN: r = ~b;
            OP_AND, OP_TST: r = a & b;
            OP_ORR: r = a | b;
            OP_EOR: r = a ^ b;
            OP_LDR: begin r = W'(ua + ub); upd = 1'b0; end
            OP_STR: begin r = W'(ua - ub); upd = 1'b0; end
            OP_ADD, OP_ADC: begin
                bor = (cmd == OP_ADC) ? int'(m_flags[2]) : 0;
                cn  = (ua + ub + longint'(bor)) > mask;
                sr  = sa + sb + bor;
                v   = (sr > smax) || (sr < smin);
                r   = W'(ua + ub + longint'(bor));
            end
            OP_SUB, OP_CMP, OP_SBC: begin
                bor = (cmd == OP_SBC) ? 1 - int'(m_flags[2]) : 0;
                cn  = ua >= ub + longint'(bor);
                sr  = sa - sb - bor;
                v   = (sr > smax) || (sr < smin);
                r   = W'(ua - ub - longint'(bor));
            end
            OP_MUL: r = W'(ua * ub);
            default: begin r = '0; upd = 1'b0; end
        endcase
        if (upd && (s || cmd == OP_CMP || cmd == OP_TST))
            m_flags = {r == '0, cn, r[W-1], v};
        return {r, m_flags};
    endfunction

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_output: got res %0h expected no output", res);
            end else begin
                logic [W+3:0] e;
                e = exp_q.pop_front();
                check("sb_res", 64'(res), 64'(e[W+3:4]));
                check("sb_status", 64'(status_reg), 64'(e[3:0]));
            end
        end
    end

    task automatic send(input logic [3:0] cmd, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s);
        int k;
        bit ok;
        k = 0; ok = 1'b0;
        in_valid = 1'b1; exec_cmd = cmd; val_1 = a; val_2 = b; s_bit = s;
        while (k < 200) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            k++;
        end
        if (ok) begin
            exp_q.push_back(model(cmd, a, b, s));
            last_acc = cyc + 1;
        end else begin
            check("accept_timeout", 64'(0), 64'(1));
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        val_1 = $urandom; val_2 = $urandom; exec_cmd = 4'($urandom); s_bit = 1'($urandom);
    endtask

    task automatic wait_out(output int lat, output bit busy_rdy);
        lat = 0; busy_rdy = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            if (out_valid) break;
            if (in_ready) busy_rdy = 1'b1;
            lat++;
        end
    endtask

    task automatic run8(input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b,
                        input logic s, output int lat);
        int k;
        k = 0;
        in_valid8 = 1'b1; cmd8 = cmd; a8 = a; b8 = b; s8 = s;
        while (k < 50) begin
            @(negedge clk);
            if (in_ready8) break;
            k++;
        end
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 0;
        while (lat < 200) begin
            @(negedge clk);
            if (out_valid8) break;
            lat++;
        end
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W-1){1'b1}}};
            3: return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, a1, a2, k;
        bit br;
        logic [W-1:0] held;
        rst = 1'b1; in_valid = 1'b0; val_1 = '0; val_2 = '0; exec_cmd = '0; s_bit = 1'b0;
        forced_ready = 1'b1; rand_ready = 1'b0;
        in_valid8 = 1'b0; a8 = '0; b8 = '0; cmd8 = '0; s8 = 1'b0; out_ready8 = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_res", 64'(res), 64'(0));
        check("rst_status", 64'(status_reg), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        rst = 1'b0;
        @(posedge clk); #1;

        send(OP_ADD, 32'h7FFF_FFFF, 32'h1, 1'b1);
        wait_out(lat, br);
        check("add_latency", 64'(lat), 64'(1));
        check("add_ovf_res", 64'(res), 64'h8000_0000);
        check("add_ovf_status", 64'(status_reg), 64'(4'b0011));
        @(posedge clk); #1;

        send(OP_SUB, 32'd5, 32'd5, 1'b1);
        a1 = last_acc;
        send(OP_SBC, 32'd10, 32'd3, 1'b1);
        a2 = last_acc;
        check("b2b_gap", 64'(a2 - a1), 64'(2));
        wait_out(lat, br);
        check("sbc_latency", 64'(lat), 64'(1));
        check("sbc_res", 64'(res), 64'(7));
        check("sbc_carry", 64'(status_reg[2]), 64'(1));
        @(posedge clk); #1;

        send(OP_MUL, 32'h0000_FFFF, 32'h0001_0001, 1'b1);
        wait_out(lat, br);
        check("mul_latency", 64'(lat), 64'(W + 1));
        check("mul_busy_in_ready", 64'(br), 64'(0));
        check("mul_res", 64'(res), 64'hFFFF_FFFF);
        check("mul_status", 64'(status_reg), 64'(4'b0110));
        @(posedge clk); #1;

        forced_ready = 1'b0;
        send(OP_ORR, 32'h0F0, 32'h00F, 1'b1);
        wait_out(lat, br);
        held = res;
        in_valid = 1'b1; exec_cmd = OP_ADD; val_1 = 32'd1; val_2 = 32'd1; s_bit = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_out_valid", 64'(out_valid), 64'(1));
            check("hold_res", 64'(res), 64'(held));
            check("hold_in_ready", 64'(in_ready), 64'(0));
        end
        check("hold_res_value", 64'(held), 64'h0FF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        forced_ready = 1'b1;
        @(posedge clk); #1;

        send(OP_MUL, 32'd3, 32'd5, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out_valid", 64'(out_valid), 64'(0));
        check("abort_status", 64'(status_reg), 64'(0));
        exp_q.delete();
        m_flags = 4'b0000;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        send(OP_ADD, 32'd2, 32'd3, 1'b0);
        wait_out(lat, br);
        check("post_rst_latency", 64'(lat), 64'(1));
        check("post_rst_res", 64'(res), 64'(5));
        @(posedge clk); #1;

        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            send(4'($urandom_range(0, 15)), pick(), pick(), 1'($urandom));
        end
        k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 64'(exp_q.size()), 64'(0));
        rand_ready = 1'b0;
        forced_ready = 1'b1;
        @(posedge clk); #1;

        run8(OP_ADD, 8'hFF, 8'h01, 1'b1, lat);
        check("w8_add_latency", 64'(lat), 64'(1));
        check("w8_add_res", 64'(res8), 64'(0));
        check("w8_add_status", 64'(status8), 64'(4'b1100));
        @(posedge clk); #1;
        run8(OP_MUL, 8'd3, 8'd5, 1'b1, lat);
        check("w8_mul_latency", 64'(lat), 64'(9));
        check("w8_mul_res", 64'(res8), 64'(15));
        check("w8_mul_status", 64'(status8), 64'(4'b0100));
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
